// File: rtl/linear_net_pkg.sv
// Shared helpers for the multicast linear distribution chain.
// Tags are decoded into at most MASK_W (32) destination bits, which bounds NUM_NODE.
package linear_net_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int MASK_W      = 32;

  function automatic int calc_cmd_width(input int multicast, input int num_node);
    return (multicast != 0) ? num_node : $clog2(num_node);
  endfunction

  function automatic logic [MASK_W-1:0] tag_to_mask(input logic [MASK_W-1:0] cmd,
                                                    input int multicast,
                                                    input int num_node);
    logic [MASK_W-1:0] mask;
    mask = '0;
    if (multicast != 0) begin
      mask = cmd & ((MASK_W'(1) << num_node) - MASK_W'(1));
    end else if (cmd < MASK_W'(num_node)) begin
      mask[cmd[4:0]] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic any_bit_above(input logic [MASK_W-1:0] mask, input int k);
    return (mask >> (k + 1)) != '0;
  endfunction

endpackage

// File: rtl/linear_net_tap.sv
// One chain tap: a single output register with valid/ready handshake.
// The register clears its data when it drains so an idle node always reads 0.
module linear_net_tap #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_mask_bit,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_adv,
  input  logic                  i_out_ready,
  output logic                  o_need,
  output logic                  o_can_load,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  assign o_need     = i_valid & i_mask_bit;
  assign o_can_load = ~r_valid | i_out_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_adv & o_need) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

endmodule

// File: rtl/linear_network_multicast_seq.sv
// Daisy-chain distributor: one word per cycle to NUM_NODE taps by unicast index or multicast mask.
// Define LINEAR_NET_STALL_CNT_EN to build the saturating stall-cycle counter on o_stall_cnt.
module linear_network_multicast_seq
  import linear_net_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_NODE   = 4,
  parameter int MULTICAST  = 1,
  parameter int CMD_WIDTH  = calc_cmd_width(MULTICAST, NUM_NODE)
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [CMD_WIDTH-1:0]           i_cmd,
  output logic                           o_in_ready,
  output logic [NUM_NODE-1:0]            o_valid,
  output logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus,
  input  logic [NUM_NODE-1:0]            i_out_ready,
  output logic                           o_drop,
  output logic [STALL_CNT_W-1:0]         o_stall_cnt
);

  localparam int NF = NUM_NODE - 1;

  logic [NUM_NODE-1:0]   w_inMask;
  logic [NUM_NODE-1:0]   w_examValid;
  logic [DATA_WIDTH-1:0] w_examData [NUM_NODE];
  logic [NUM_NODE-1:0]   w_examMask [NUM_NODE];
  logic [NUM_NODE-1:0]   w_need;
  logic [NUM_NODE-1:0]   w_canLoad;
  logic [NUM_NODE-1:0]   w_stallTerm;
  logic                  w_stall;
  logic                  w_adv;

  logic [NF-1:0]         r_fwdValid;
  logic [DATA_WIDTH-1:0] r_fwdData [NF];
  logic [NUM_NODE-1:0]   r_fwdMask [NF];
  logic                  r_drop;

  assign w_inMask = NUM_NODE'(tag_to_mask(MASK_W'(i_cmd), MULTICAST, NUM_NODE));

  for (genvar k = 0; k < NUM_NODE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_examValid[k] = i_valid;
      assign w_examData[k]  = i_data_bus;
      assign w_examMask[k]  = w_inMask;
      // Head stall ignores i_valid so that o_in_ready never depends on it combinationally.
      assign w_stallTerm[k] = w_inMask[0] & ~w_canLoad[0];
    end else begin : g_body
      assign w_examValid[k] = r_fwdValid[k-1];
      assign w_examData[k]  = r_fwdData[k-1];
      assign w_examMask[k]  = r_fwdMask[k-1];
      assign w_stallTerm[k] = w_need[k] & ~w_canLoad[k];
    end

    linear_net_tap #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_tap (
      .CLK         (CLK),
      .rst         (rst),
      .i_valid     (w_examValid[k]),
      .i_mask_bit  (w_examMask[k][k]),
      .i_data      (w_examData[k]),
      .i_adv       (w_adv),
      .i_out_ready (i_out_ready[k]),
      .o_need      (w_need[k]),
      .o_can_load  (w_canLoad[k]),
      .o_valid     (o_valid[k]),
      .o_data      (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign w_stall    = |w_stallTerm;
  assign w_adv      = i_en & ~w_stall;
  assign o_in_ready = w_adv & ~rst;
  assign o_drop     = r_drop;

  // fwd[k] captures whatever stage k examined; it stays valid only while later taps still want it.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_fwdValid <= '0;
      for (int k = 0; k < NF; k++) begin
        r_fwdData[k] <= '0;
        r_fwdMask[k] <= '0;
      end
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_adv & i_valid & (w_inMask == '0);
      if (w_adv) begin
        for (int k = 0; k < NF; k++) begin
          r_fwdValid[k] <= w_examValid[k] & any_bit_above(MASK_W'(w_examMask[k]), k);
          r_fwdData[k]  <= w_examData[k];
          r_fwdMask[k]  <= w_examMask[k];
        end
      end
    end
  end

`ifdef LINEAR_NET_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stallCnt;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (i_en & w_stall & ~(&r_stallCnt)) begin
      r_stallCnt <= r_stallCnt + STALL_CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stallCnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
